// File: rtl/subtractor_serial_pkg.sv
// Shared definitions for the slice-serial signed subtractor: state encoding and width derivation.
// The max macro is guarded so repeated inclusion in one compilation unit stays harmless.
`ifndef SUBTRACTOR_SERIAL_MAX
`define SUBTRACTOR_SERIAL_MAX(x, y) (((x) > (y)) ? (x) : (y))
`endif

package subtractor_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_bits(input int wa, input int wb);
        return `SUBTRACTOR_SERIAL_MAX(wa, wb);
    endfunction

    function automatic int calc_n(input int wa, input int wb, input int sl);
        return calc_bits(wa, wb) / sl;
    endfunction

endpackage

// File: rtl/subtractor_slice.sv
// Combinational SLICE-bit adder stage: sum of a, pre-inverted b and carry-in.
// No latency, no flow control; the caller feeds ~b so the stage subtracts.
module subtractor_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] nb,
    input  logic             ci,
    output logic [SLICE-1:0] sum,
    output logic             co
);

    assign {co, sum} = {1'b0, a} + {1'b0, nb} + {{SLICE{1'b0}}, ci};

endmodule

// File: rtl/subtractor_serial.sv
// Signed a - b - borrow_in computed SLICE bits per cycle; result valid N cycles after accept.
// Single operand/result slot: in_ready only in IDLE, result held in DONE until out_ready.
module subtractor_serial
    import subtractor_serial_pkg::*;
#(
    parameter  int WIDTH_A = 16,
    parameter  int WIDTH_B = 16,
    parameter  int SLICE   = 4,
    localparam int BITS    = calc_bits(WIDTH_A, WIDTH_B)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH_A-1:0] a,
    input  logic [WIDTH_B-1:0] b,
    input  logic               borrow_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BITS-1:0]    diff,
    output logic               borrow_out,
    output logic               ovf,
    output logic               busy
);

    localparam int N  = calc_n(WIDTH_A, WIDTH_B, SLICE);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (BITS % SLICE != 0) begin : g_bad_slice
        $error("subtractor_serial: BITS must be a multiple of SLICE");
    end

    state_t            state_q;
    state_t            state_d;
    logic [BITS-1:0]   a_q;
    logic [BITS-1:0]   nb_q;
    logic [BITS-1:0]   res_q;
    logic              carry_q;
    logic [CW-1:0]     cnt_q;
    logic              borrow_q;
    logic              ovf_q;

    logic [BITS-1:0]   a_ext;
    logic [BITS-1:0]   b_ext;
    logic [SLICE-1:0]  a_sl;
    logic [SLICE-1:0]  nb_sl;
    logic [SLICE-1:0]  sum;
    logic              co;
    logic              accept;
    logic              last;

    // Size casts of signed operands sign-extend the narrower input.
    assign a_ext  = BITS'($signed(a));
    assign b_ext  = BITS'($signed(b));
    assign accept = in_valid & in_ready;
    assign last   = (cnt_q == LAST);
    assign a_sl   = a_q[int'(cnt_q) * SLICE +: SLICE];
    assign nb_sl  = nb_q[int'(cnt_q) * SLICE +: SLICE];

    subtractor_slice #(.SLICE(SLICE)) u_slice (
        .a   (a_sl),
        .nb  (nb_sl),
        .ci  (carry_q),
        .sum (sum),
        .co  (co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            nb_q     <= '0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            a_q     <= a_ext;
            nb_q    <= ~b_ext;
            carry_q <= ~borrow_in;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            res_q[int'(cnt_q) * SLICE +: SLICE] <= sum;
            carry_q <= co;
            cnt_q   <= cnt_q + 1'b1;
            if (last) begin
                borrow_q <= ~co;
                // Operand signs differ when a and ~b share a top bit; sum's top bit is the result sign.
                ovf_q    <= (a_q[BITS-1] == nb_q[BITS-1]) && (sum[SLICE-1] != a_q[BITS-1]);
            end
        end
    end

    assign diff       = res_q;
    assign borrow_out = borrow_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_subtractor_serial.sv
// Bench for subtractor_serial (16-bit a, 8-bit b, 4-bit slices): directed cases plus random
// transactions compared with an integer-arithmetic reference.
module tb_subtractor_serial;

    localparam int WA   = 16;
    localparam int WB   = 8;
    localparam int SL   = 4;
    localparam int BITS = 16;
    localparam int N    = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [WA-1:0]   a = '0;
    logic [WB-1:0]   b = '0;
    logic            borrow_in = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [BITS-1:0] diff;
    logic            borrow_out;
    logic            ovf;
    logic            busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    subtractor_serial #(.WIDTH_A(WA), .WIDTH_B(WB), .SLICE(SL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out),
        .ovf        (ovf),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain signed/unsigned integer arithmetic on the extended operands.
    task automatic model(input logic [15:0] ta, input logic [7:0] tb, input logic tbin,
                         output logic [15:0] ediff, output logic ebo, output logic eovf);
        int sa, sb, r, ua, ub;
        sa = $signed(ta);
        sb = $signed(tb);
        r  = sa - sb - int'(tbin);
        ediff = r[15:0];
        eovf  = (r > 32767) || (r < -32768);
        ua = int'(ta);
        ub = sb & 32'hFFFF;
        ebo = (ua < ub + int'(tbin));
    endtask

    task automatic accept(input logic [15:0] ta, input logic [7:0] tb, input logic tbin);
        int w;
        in_valid  = 1'b1;
        a         = ta;
        b         = tb;
        borrow_in = tbin;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check("accept_wait", (w < 20), 1);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        a         = WA'($urandom);
        b         = WB'($urandom);
        borrow_in = 1'($urandom);
        check("busy_after_accept", busy, 1);
    endtask

    task automatic wait_done();
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", cyc, N);
    endtask

    task automatic check_result(input string tag, input logic [15:0] ediff, input logic ebo,
                                input logic eovf);
        check({tag, "_diff"}, diff, ediff);
        check({tag, "_borrow"}, borrow_out, ebo);
        check({tag, "_ovf"}, ovf, eovf);
        check({tag, "_in_ready"}, in_ready, 0);
    endtask

    task automatic release_out(input string tag, input logic [15:0] ediff);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_vld_drop"}, out_valid, 0);
        check({tag, "_idle"}, {busy, in_ready}, 2'b01);
        check({tag, "_diff_kept"}, diff, ediff);
    endtask

    initial begin
        logic [15:0] ra, ediff;
        logic [7:0]  rb;
        logic        rbin, ebo, eovf;
        int          hold;

        #12;
        check("rst_outputs", {out_valid, busy, borrow_out, ovf}, 4'b0000);
        check("rst_in_ready", in_ready, 1);
        check("rst_diff", diff, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        accept(16'h0005, 8'h03, 1'b0);
        wait_done();
        check_result("t1", 16'h0002, 1'b0, 1'b0);
        release_out("t1", 16'h0002);

        accept(16'h0000, 8'hFF, 1'b0);
        wait_done();
        check_result("t2", 16'h0001, 1'b1, 1'b0);
        release_out("t2", 16'h0001);

        accept(16'h8000, 8'h01, 1'b0);
        wait_done();
        check_result("t3", 16'h7FFF, 1'b0, 1'b1);
        release_out("t3", 16'h7FFF);

        accept(16'h0010, 8'h10, 1'b1);
        wait_done();
        check_result("t4", 16'hFFFF, 1'b1, 1'b0);
        release_out("t4", 16'hFFFF);

        // Backpressure: result must hold while new operands wait at the input.
        accept(16'h1111, 8'h22, 1'b0);
        wait_done();
        check_result("t5", 16'h10EF, 1'b0, 1'b0);
        in_valid  = 1'b1;
        a         = 16'h0100;
        b         = 8'h01;
        borrow_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("t5_hold", {out_valid, in_ready, diff}, {2'b10, 16'h10EF});
        end
        release_out("t5", 16'h10EF);
        @(posedge clk); #1;
        check("t5_next_taken", busy, 1);
        in_valid = 1'b0;
        wait_done();
        check_result("t5b", 16'h00FF, 1'b0, 1'b0);
        release_out("t5b", 16'h00FF);

        // Asynchronous reset in the middle of a run.
        accept(16'h7777, 8'h11, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_outputs", {out_valid, busy, borrow_out, ovf}, 4'b0000);
        check("t6_rst_in_ready", in_ready, 1);
        check("t6_rst_diff", diff, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        accept(16'h1234, 8'h34, 1'b0);
        wait_done();
        check_result("t6", 16'h1200, 1'b0, 1'b0);
        release_out("t6", 16'h1200);

        for (int i = 0; i < 40; i++) begin
            ra   = 16'($urandom);
            rb   = 8'($urandom);
            rbin = 1'($urandom);
            model(ra, rb, rbin, ediff, ebo, eovf);
            accept(ra, rb, rbin);
            wait_done();
            check_result("rnd", ediff, ebo, eovf);
            hold = $urandom_range(0, 3);
            repeat (hold) begin
                @(posedge clk); #1;
            end
            check("rnd_hold_vld", out_valid, 1);
            release_out("rnd", ediff);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
